// File: rtl/adder_pipelined_nbit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pipe_pkg
//  Purpose  : Shared types and helpers for the pipelined n-bit adder.
//             slice_lo()  - base bit index of pipeline slice k
//             DEFAULT_SW  - default slice width (16-bit adder, 4 stages)
//             stage_cv_t  - per-stage registered carry / valid pair
//  Revision : 1.0 - initial release
// ============================================================================
package adder_pipe_pkg;

    localparam int DEFAULT_SW = 4;

    typedef struct packed {
        logic carry;
        logic valid;
    } stage_cv_t;

    function automatic int slice_lo(input int k, input int sw);
        return k * sw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_pipelined_nbit_if.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pipelined_nbit_if
//  Purpose  : Operand / result handshake bundle of the pipelined adder.
//             Operand side : in_valid, in_ready, a, b, carry_in, sub
//             Result side  : out_valid, out_ready, sum, carry_out, overflow
//             slave  - adder view, master - producer/consumer view
//  Revision : 1.0 - initial release
// ============================================================================
interface adder_pipelined_nbit_if #(
    parameter int BIT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic                 carry_in;
    logic                 sub;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] sum;
    logic                 carry_out;
    logic                 overflow;

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/adder_pipelined_nbit_slice.sv
`default_nettype none
// ============================================================================
//  Module   : adder_slice
//  Purpose  : SW-bit combinational slice adder.
//             a, b, cin      - slice operands and carry in
//             sum, cout      - slice result and carry out of slice MSB
//             c_msb_in       - carry into the slice MSB (signed overflow
//                              detection on the top slice)
//  Revision : 1.0 - initial release
// ============================================================================
module adder_slice #(
    parameter int SW = 4
) (
    input  wire logic [SW-1:0] a,
    input  wire logic [SW-1:0] b,
    input  wire logic          cin,
    output logic      [SW-1:0] sum,
    output logic               cout,
    output logic               c_msb_in
);
    logic [SW:0] w_full;

    assign w_full   = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    assign sum      = w_full[SW-1:0];
    assign cout     = w_full[SW];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
    assign c_msb_in = w_full[SW-1] ^ a[SW-1] ^ b[SW-1];
endmodule
`default_nettype wire

// File: rtl/adder_pipelined_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pipelined_nbit
//  Purpose  : BIT_WIDTH add/subtract split into NUM_STAGES carry-registered
//             slices with valid/ready handshake and full back-pressure.
//             clk   - system clock, rising edge
//             n_rst - asynchronous active-low reset
//             bus   - adder_pipelined_nbit_if.slave (operands in, result out)
//  Options  : ADDER_PIPE_ASSERT_EN - simulation checks (X on accepted inputs,
//             reference scoreboard, output stability under stall)
//  Revision : 1.0 - initial release
// ============================================================================
module adder_pipelined_nbit
    import adder_pipe_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int NUM_STAGES = 4
) (
    input  wire logic               clk,
    input  wire logic               n_rst,
    adder_pipelined_nbit_if.slave   bus
);
    localparam int SW = BIT_WIDTH / NUM_STAGES;

    logic                 r_init;
    stage_cv_t            r_cv   [NUM_STAGES];
    logic [BIT_WIDTH-1:0] r_a    [NUM_STAGES];
    logic [BIT_WIDTH-1:0] r_b    [NUM_STAGES];
    logic [BIT_WIDTH-1:0] r_sum  [NUM_STAGES];
    logic                 r_ovf;

    logic                 w_advance;
    logic                 w_accept;
    logic [BIT_WIDTH-1:0] w_b_eff;
    logic                 w_c0;
    logic [BIT_WIDTH-1:0] w_a_in    [NUM_STAGES];
    logic [BIT_WIDTH-1:0] w_b_in    [NUM_STAGES];
    logic [BIT_WIDTH-1:0] w_sum_in  [NUM_STAGES];
    logic [BIT_WIDTH-1:0] w_sum_nxt [NUM_STAGES];
    logic                 w_c_in    [NUM_STAGES];
    logic                 w_v_in    [NUM_STAGES];
    logic                 w_cout    [NUM_STAGES];
    logic                 w_ovf;

    // Whole pipeline moves in lockstep; it only stalls when a finished
    // result is waiting on a consumer that is not ready.
    assign w_advance    = ~r_cv[NUM_STAGES-1].valid | bus.out_ready;
    // r_init keeps the input closed for the first cycle after reset release.
    assign bus.in_ready = r_init & w_advance;
    assign w_accept     = bus.in_valid & bus.in_ready;

    // Subtraction as a + ~b + 1.
    assign w_b_eff = bus.sub ? ~bus.b : bus.b;
    assign w_c0    = bus.sub ? 1'b1 : bus.carry_in;

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            localparam int                   LO         = slice_lo(k, SW);
            localparam logic [BIT_WIDTH-1:0] SLICE_MASK = BIT_WIDTH'({SW{1'b1}}) << LO;

            logic [SW-1:0] w_slice;
            logic          w_cmsb;

            if (k == 0) begin : g_first
                assign w_a_in[k]   = bus.a;
                assign w_b_in[k]   = w_b_eff;
                assign w_sum_in[k] = '0;
                assign w_c_in[k]   = w_c0;
                assign w_v_in[k]   = w_accept;
            end else begin : g_next
                assign w_a_in[k]   = r_a[k-1];
                assign w_b_in[k]   = r_b[k-1];
                assign w_sum_in[k] = r_sum[k-1];
                assign w_c_in[k]   = r_cv[k-1].carry;
                assign w_v_in[k]   = r_cv[k-1].valid;
            end

            adder_slice #(.SW(SW)) u_slice (
                .a        (w_a_in[k][LO +: SW]),
                .b        (w_b_in[k][LO +: SW]),
                .cin      (w_c_in[k]),
                .sum      (w_slice),
                .cout     (w_cout[k]),
                .c_msb_in (w_cmsb)
            );

            // Lower slices ride along unchanged; this stage fills in slice k.
            assign w_sum_nxt[k] = (w_sum_in[k] & ~SLICE_MASK) | (BIT_WIDTH'(w_slice) << LO);

            if (k == NUM_STAGES - 1) begin : g_last
                assign w_ovf = w_cmsb ^ w_cout[k];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_init <= 1'b0;
        end else begin
            r_init <= 1'b1;
        end
    end

    // Data registers load only with a valid beat so bubbles leave the
    // last result visible on the (invalid) output rather than garbage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_cv[k]  <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_cv[k].valid <= w_v_in[k];
                if (w_v_in[k]) begin
                    r_cv[k].carry <= w_cout[k];
                    r_a[k]        <= w_a_in[k];
                    r_b[k]        <= w_b_in[k];
                    r_sum[k]      <= w_sum_nxt[k];
                end
            end
            if (w_v_in[NUM_STAGES-1]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign bus.out_valid = r_cv[NUM_STAGES-1].valid;
    assign bus.sum       = r_sum[NUM_STAGES-1];
    assign bus.carry_out = r_cv[NUM_STAGES-1].carry;
    assign bus.overflow  = r_ovf;

`ifdef ADDER_PIPE_ASSERT_EN
    // Reference entries: {overflow, carry_out, sum}
    logic [BIT_WIDTH+1:0] r_ref_q [$];
    logic                 r_hold_chk;
    logic [BIT_WIDTH+1:0] r_hold_dat;
    logic [BIT_WIDTH:0]   w_ref_full;
    logic                 w_ref_ovf;
    logic [BIT_WIDTH+1:0] w_ref_exp;

    assign w_ref_full = {1'b0, bus.a} + {1'b0, w_b_eff} + {{BIT_WIDTH{1'b0}}, w_c0};
    assign w_ref_ovf  = (bus.a[BIT_WIDTH-1] == w_b_eff[BIT_WIDTH-1]) &&
                        (w_ref_full[BIT_WIDTH-1] != bus.a[BIT_WIDTH-1]);

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ref_q.delete();
            r_hold_chk <= 1'b0;
            r_hold_dat <= '0;
        end else begin
            if (w_accept) begin
                a_in_known: assert (!$isunknown({bus.a, bus.b, bus.carry_in, bus.sub}))
                    else $error("adder_pipelined_nbit: X/Z operand on accepted beat");
                r_ref_q.push_back({w_ref_ovf, w_ref_full});
            end
            if (bus.out_valid && bus.out_ready) begin
                w_ref_exp = (r_ref_q.size() > 0) ? r_ref_q.pop_front() : '0;
                a_scoreboard: assert ({bus.overflow, bus.carry_out, bus.sum} == w_ref_exp)
                    else $error("adder_pipelined_nbit: result %h != reference %h",
                                {bus.overflow, bus.carry_out, bus.sum}, w_ref_exp);
            end
            if (r_hold_chk) begin
                a_stall_hold: assert (bus.out_valid &&
                                      {bus.overflow, bus.carry_out, bus.sum} == r_hold_dat)
                    else $error("adder_pipelined_nbit: output changed during stall");
            end
            r_hold_chk <= bus.out_valid & ~bus.out_ready;
            r_hold_dat <= {bus.overflow, bus.carry_out, bus.sum};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_pipelined_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_pipelined_nbit
//  Purpose  : Directed self-checking bench for adder_pipelined_nbit
//             (16-bit/4-stage instance and 8-bit/1-stage instance).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipelined_nbit;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    always #5 clk = ~clk;

    adder_pipelined_nbit_if #(.BIT_WIDTH(16)) bus4 ();
    adder_pipelined_nbit_if #(.BIT_WIDTH(8))  bus1 ();

    adder_pipelined_nbit #(.BIT_WIDTH(16), .NUM_STAGES(4)) dut4 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus4.slave)
    );

    adder_pipelined_nbit #(.BIT_WIDTH(8), .NUM_STAGES(1)) dut1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus1.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          idx;
    int          nb;
    int          no;
    logic        acc;
    logic        prev_hold;
    logic [15:0] prev_sum;
    logic [15:0] exp16;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive4(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic s);
        bus4.in_valid = v;
        bus4.a        = a;
        bus4.b        = b;
        bus4.carry_in = cin;
        bus4.sub      = s;
    endtask

    // One isolated beat through the 4-stage instance: exact latency 4.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic s, input logic [15:0] e_sum,
                           input logic e_c, input logic e_o);
        bus4.out_ready = 1'b1;
        drive4(1'b1, a, b, cin, s);
        #1;
        chk1({tag, " in_ready"}, bus4.in_ready, 1'b1);
        tick();
        drive4(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            chk1({tag, " early out_valid"}, bus4.out_valid, 1'b0);
            tick();
        end
        chk1 ({tag, " out_valid"}, bus4.out_valid, 1'b1);
        chk16({tag, " sum"},       bus4.sum,       e_sum);
        chk1 ({tag, " carry_out"}, bus4.carry_out, e_c);
        chk1 ({tag, " overflow"},  bus4.overflow,  e_o);
        tick();
        chk1({tag, " single beat"}, bus4.out_valid, 1'b0);
    endtask

    initial begin
        drive4(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        bus4.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.a         = 8'h00;
        bus1.b         = 8'h00;
        bus1.carry_in  = 1'b0;
        bus1.sub       = 1'b0;
        bus1.out_ready = 1'b1;

        // ---------------- reset state ----------------
        #12;
        chk1 ("rst out_valid", bus4.out_valid, 1'b0);
        chk16("rst sum",       bus4.sum,       16'h0000);
        chk1 ("rst carry_out", bus4.carry_out, 1'b0);
        chk1 ("rst overflow",  bus4.overflow,  1'b0);
        chk1 ("rst out_valid n1", bus1.out_valid, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        chk1("in_ready after reset", bus4.in_ready, 1'b1);

        // ---------------- directed arithmetic ----------------
        run_one("add 00FF+0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_one("add 7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("add FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("add cin",       16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
        run_one("sub 0003-0005", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub 8000-0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_one("sub ignores cin", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

        // ---------------- back-to-back 8 beats ----------------
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc < 8) drive4(1'b1, 16'(cyc) * 16'h1357, 16'hA5A5, 1'b0, 1'b0);
            else         drive4(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            tick();
            chk1("b2b out_valid", bus4.out_valid, (cyc >= 3 && cyc <= 10));
            if (bus4.out_valid && idx < 8) begin
                exp16 = 16'(idx) * 16'h1357 + 16'hA5A5;
                chk16("b2b sum", bus4.sum, exp16);
                idx++;
            end
        end
        chkint("b2b count", idx, 8);

        // ---------------- 5-cycle stall with back-pressure ----------------
        nb        = 0;
        no        = 0;
        prev_hold = 1'b0;
        prev_sum  = 16'h0000;
        for (int cyc = 0; cyc < 40 && no < 8; cyc++) begin
            bus4.out_ready = !(cyc >= 4 && cyc < 9);
            if (nb < 8) drive4(1'b1, 16'(nb) * 16'h0F0F, 16'h1234, 1'b0, 1'b0);
            else        drive4(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
            #1;
            if (prev_hold) begin
                chk1 ("stall out_valid held", bus4.out_valid, 1'b1);
                chk16("stall sum frozen",     bus4.sum,       prev_sum);
            end
            if (bus4.out_valid && !bus4.out_ready) begin
                chk1("stall in_ready", bus4.in_ready, 1'b0);
            end
            acc = bus4.in_valid & bus4.in_ready;
            if (bus4.out_valid && bus4.out_ready) begin
                exp16 = 16'(no) * 16'h0F0F + 16'h1234;
                chk16("stall stream sum", bus4.sum, exp16);
                no++;
            end
            prev_hold = bus4.out_valid & ~bus4.out_ready;
            prev_sum  = bus4.sum;
            tick();
            if (acc) nb++;
        end
        chkint("stall results out", no, 8);
        chkint("stall beats in",    nb, 8);
        bus4.out_ready = 1'b1;
        drive4(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk1("stall no duplicate", bus4.out_valid, 1'b0);
            tick();
        end

        // ---------------- reset with beats in flight ----------------
        for (int k = 0; k < 3; k++) begin
            drive4(1'b1, 16'hF000, 16'hF000 + 16'(k), 1'b0, 1'b0);
            tick();
        end
        drive4(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        chk1 ("inflight out_valid", bus4.out_valid, 1'b1);
        chk16("inflight sum",       bus4.sum,       16'hE000);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk1 ("async rst out_valid", bus4.out_valid, 1'b0);
        chk16("async rst sum",       bus4.sum,       16'h0000);
        chk1 ("async rst carry_out", bus4.carry_out, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1("post-rst no partial", bus4.out_valid, 1'b0);
        end
        run_one("post-rst beat", 16'hF000, 16'hF000, 1'b0, 1'b0, 16'hE000, 1'b1, 1'b0);

        // ---------------- single-stage 8-bit instance ----------------
        bus1.in_valid = 1'b1;
        bus1.a        = 8'hF0;
        bus1.b        = 8'h0F;
        bus1.carry_in = 1'b1;
        bus1.sub      = 1'b0;
        #1;
        chk1("n1 in_ready", bus1.in_ready, 1'b1);
        tick();
        bus1.a        = 8'h80;
        bus1.b        = 8'h01;
        bus1.carry_in = 1'b0;
        bus1.sub      = 1'b1;
        chk1 ("n1 out_valid",  bus1.out_valid, 1'b1);
        chk16("n1 sum",        16'(bus1.sum),  16'h0000);
        chk1 ("n1 carry_out",  bus1.carry_out, 1'b1);
        chk1 ("n1 overflow",   bus1.overflow,  1'b0);
        tick();
        bus1.in_valid = 1'b0;
        chk1 ("n1 sub out_valid", bus1.out_valid, 1'b1);
        chk16("n1 sub sum",       16'(bus1.sum),  16'h007F);
        chk1 ("n1 sub carry_out", bus1.carry_out, 1'b1);
        chk1 ("n1 sub overflow",  bus1.overflow,  1'b1);
        tick();
        chk1("n1 bubble", bus1.out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
